// File: rtl/johnson_pkg.sv
// ---------------------------------------------------------------------------
// johnson_pkg
// Shared definitions for the Johnson/ring sequence generator.
//   mode_t       : operating mode encoding driven on the 2-bit mode input
//   phase_width  : width of the decoded phase index for a given counter width
// ---------------------------------------------------------------------------
package johnson_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD    = 2'b00,
    MODE_JOHNSON = 2'b01,
    MODE_RING    = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_t;

  // A Johnson counter of width W walks 2*W distinct codes, so the phase
  // index needs enough bits to count 0..2*W-1. Ring mode needs fewer and
  // shares the same port.
  function automatic int phase_width(input int width);
    return $clog2(2 * width);
  endfunction

endpackage

// File: rtl/johnson_prescaler.sv
// ---------------------------------------------------------------------------
// johnson_prescaler
// Free-running step-opportunity prescaler. The internal count pc advances
// every cycle; once it reaches div the tick output is high for that cycle
// and the count restarts from zero, giving one tick every div+1 cycles.
//
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset, clears the count
//   clear : synchronous restart of the count (used by parallel load)
//   div   : divisor; 0 gives a tick every cycle
//   tick  : combinational, high on cycles where a step may occur
// ---------------------------------------------------------------------------
module johnson_prescaler
  import johnson_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] pc;

  // Compare with >= rather than == so that lowering div while pc is
  // already above the new value still produces a tick on the next compare
  // instead of letting pc run all the way round.
  assign tick = (pc >= div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else if (clear || tick) begin
      pc <= '0;
    end else begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/johnson_seq_gen.sv
// ---------------------------------------------------------------------------
// johnson_seq_gen
// Johnson / ring sequence generator with prescaled stepping, direction
// control, parallel load, phase decode, wrap pulse and illegal-state
// detection with optional self-correction.
//
// Parameters:
//   WIDTH   : counter width in bits (2..32)
//   DIV_W   : prescaler divisor width
//   AUTOFIX : 1 = a step from an illegal code reseeds the counter,
//             0 = illegal codes keep shifting under the normal rule
//
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset (q, prescaler, wrap cleared)
//   en       : step enable (prescaler keeps running when low)
//   mode     : 00 hold, 01 Johnson, 10 ring, 11 reserved (hold)
//   dir      : 0 up (shift towards LSB), 1 down (shift towards MSB)
//   load     : synchronous parallel load, highest priority
//   load_val : value written to q on load
//   div      : prescaler divisor, one step opportunity every div+1 cycles
//   q        : registered counter state
//   phase    : combinational position of q within the current sequence
//   wrap     : registered one-cycle pulse when a step completes a lap
//   illegal  : combinational, q is not a valid code for the current mode
// ---------------------------------------------------------------------------
module johnson_seq_gen
  import johnson_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int DIV_W   = 8,
  parameter  int AUTOFIX = 1,
  localparam int PW      = phase_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [DIV_W-1:0] div,
  output logic [WIDTH-1:0] q,
  output logic [PW-1:0]    phase,
  output logic             wrap,
  output logic             illegal
);

  mode_t            mode_e;
  logic             active;
  logic             tick;
  logic             step;
  logic             fixup;
  logic [WIDTH-1:0] q_shift;
  logic [WIDTH-1:0] q_seed;
  logic [WIDTH-1:0] q_step;
  logic [PW-1:0]    last_phase;
  logic [PW:0]      cur_dec;
  logic [PW:0]      nxt_dec;
  logic             wrap_hit;

  assign mode_e = mode_t'(mode);
  assign active = (mode_e == MODE_JOHNSON) || (mode_e == MODE_RING);

  // Johnson code for phase k: phases 0..WIDTH fill ones in from the MSB,
  // phases WIDTH+1..2*WIDTH-1 then fill zeros in from the MSB.
  function automatic logic [WIDTH-1:0] johnson_code(input int k);
    logic [WIDTH-1:0] c;
    c = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (k <= WIDTH) begin
        c[b] = (b >= WIDTH - k);
      end else begin
        c[b] = (b < 2 * WIDTH - k);
      end
    end
    return c;
  endfunction

  // Returns {hit, index}. hit is 0 for hold/reserved modes and for any
  // value that is not one of the valid codes of the selected sequence;
  // index is then 0.
  function automatic logic [PW:0] decode(input logic [WIDTH-1:0] v,
                                         input mode_t            m);
    logic             hit;
    logic [PW-1:0]    idx;
    logic [WIDTH-1:0] one_b;
    hit = 1'b0;
    idx = '0;
    if (m == MODE_JOHNSON) begin
      for (int k = 0; k < 2 * WIDTH; k++) begin
        if (v == johnson_code(k)) begin
          hit = 1'b1;
          idx = PW'(k);
        end
      end
    end else if (m == MODE_RING) begin
      // Ring position counts from the MSB: MSB-only is phase 0.
      for (int b = 0; b < WIDTH; b++) begin
        one_b    = '0;
        one_b[b] = 1'b1;
        if (v == one_b) begin
          hit = 1'b1;
          idx = PW'(WIDTH - 1 - b);
        end
      end
    end
    return {hit, idx};
  endfunction

  johnson_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (load),
    .div   (div),
    .tick  (tick)
  );

  // Decode of the present state under the present mode. A mode change
  // therefore re-evaluates phase/illegal immediately without touching q.
  assign cur_dec = decode(q, mode_e);
  assign phase   = cur_dec[PW] ? cur_dec[PW-1:0] : '0;
  assign illegal = active && !cur_dec[PW];

  always_comb begin
    q_shift    = q;
    q_seed     = '0;
    last_phase = '0;
    case (mode_e)
      MODE_JOHNSON: begin
        q_shift    = dir ? {q[WIDTH-2:0], ~q[WIDTH-1]} : {~q[0], q[WIDTH-1:1]};
        q_seed     = '0;
        last_phase = PW'(2 * WIDTH - 1);
      end
      MODE_RING: begin
        q_shift    = dir ? {q[WIDTH-2:0], q[WIDTH-1]} : {q[0], q[WIDTH-1:1]};
        q_seed     = {1'b1, {(WIDTH - 1){1'b0}}};
        last_phase = PW'(WIDTH - 1);
      end
      default: begin
        q_shift    = q;
        q_seed     = q;
        last_phase = '0;
      end
    endcase
  end

  assign fixup  = (AUTOFIX != 0) && illegal;
  assign q_step = fixup ? q_seed : q_shift;
  assign step   = tick && en && !load && active;

  // A lap completes when a normal shift lands on phase 0 going up or on
  // the last phase going down. A reseed is never a lap, and with
  // AUTOFIX=0 a shifted illegal code never decodes, so it cannot wrap.
  assign nxt_dec  = decode(q_shift, mode_e);
  assign wrap_hit = !fixup && nxt_dec[PW] &&
                    (nxt_dec[PW-1:0] == (dir ? last_phase : '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      q    <= load_val;
      wrap <= 1'b0;
    end else if (step) begin
      q    <= q_step;
      wrap <= wrap_hit;
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_johnson_seq_gen.sv
// ---------------------------------------------------------------------------
// tb_johnson_seq_gen
// Bench for johnson_seq_gen at WIDTH=4, DIV_W=8, AUTOFIX=1. A reference
// model walks tables of the legal codes by index; a compare process checks
// every output against it on each falling edge. Directed sequences with
// literal expectations pin the model, then randomized traffic follows.
// ---------------------------------------------------------------------------
module tb_johnson_seq_gen;

  localparam int W  = 4;
  localparam int DW = 8;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [1:0]    mode;
  logic          dir;
  logic          load;
  logic [W-1:0]  load_val;
  logic [DW-1:0] div;
  logic [W-1:0]  q;
  logic [PW-1:0] phase;
  logic          wrap;
  logic          illegal;

  always #5 clk = ~clk;

  johnson_seq_gen #(
    .WIDTH   (W),
    .DIV_W   (DW),
    .AUTOFIX (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .div      (div),
    .q        (q),
    .phase    (phase),
    .wrap     (wrap),
    .illegal  (illegal)
  );

  int compared   = 0;
  int mismatched = 0;
  bit chk_on     = 1'b0;

  logic [W-1:0] jtab [8];
  logic [W-1:0] rtab [4];

  logic [W-1:0] m_q    = '0;
  int           m_pc   = 0;
  logic         m_wrap = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int find_idx(input logic [W-1:0] v, input logic [1:0] m);
    if (m == 2'b01) begin
      for (int k = 0; k < 8; k++) if (jtab[k] == v) return k;
    end else if (m == 2'b10) begin
      for (int k = 0; k < 4; k++) if (rtab[k] == v) return k;
    end
    return -1;
  endfunction

  function automatic int m_phase(input logic [W-1:0] v, input logic [1:0] m);
    int idx;
    idx = find_idx(v, m);
    return (idx < 0) ? 0 : idx;
  endfunction

  function automatic bit m_illegal(input logic [W-1:0] v, input logic [1:0] m);
    return ((m == 2'b01) || (m == 2'b10)) && (find_idx(v, m) < 0);
  endfunction

  task automatic model_step();
    bit tk;
    int n;
    int idx;
    int nidx;
    tk     = (m_pc >= int'(div));
    m_pc   = tk ? 0 : m_pc + 1;
    m_wrap = 1'b0;
    if (load) begin
      m_q  = load_val;
      m_pc = 0;
    end else if (tk && en && ((mode == 2'b01) || (mode == 2'b10))) begin
      n   = (mode == 2'b01) ? 8 : 4;
      idx = find_idx(m_q, mode);
      if (idx < 0) begin
        m_q = (mode == 2'b01) ? 4'b0000 : 4'b1000;
      end else begin
        nidx   = dir ? (idx + n - 1) % n : (idx + 1) % n;
        m_q    = (mode == 2'b01) ? jtab[nidx] : rtab[nidx];
        m_wrap = dir ? (nidx == n - 1) : (nidx == 0);
      end
    end
  endtask

  // Reference model.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_q    = '0;
        m_pc   = 0;
        m_wrap = 1'b0;
      end else begin
        model_step();
      end
    end
  end

  // Cycle-by-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        check("m_q",       32'(q),       32'(m_q));
        check("m_phase",   32'(phase),   32'(m_phase(m_q, mode)));
        check("m_illegal", 32'(illegal), 32'(m_illegal(m_q, mode)));
        check("m_wrap",    32'(wrap),    32'(m_wrap));
      end
    end
  end

  initial begin
    logic [W-1:0] jup [8];
    logic [W-1:0] rup [4];
    logic [W-1:0] held;

    rst = 1'b1; en = 1'b0; dir = 1'b0; load = 1'b0;
    mode = 2'b00; load_val = '0; div = '0;

    for (int k = 0; k < 8; k++) begin
      if (k <= 4) jtab[k] = W'((15 << (4 - k)) & 15);
      else        jtab[k] = W'(15 >> (k - 4));
    end
    for (int k = 0; k < 4; k++) rtab[k] = W'(8 >> k);

    jup = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    rup = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};

    // Reset state.
    #3;
    check("rst_q",       32'(q),       'h0);
    check("rst_wrap",    32'(wrap),    'h0);
    check("rst_phase",   32'(phase),   'h0);
    check("rst_illegal", 32'(illegal), 'h0);
    mode = 2'b10;
    #1;
    check("rst_ring_illegal", 32'(illegal), 'h1);
    check("rst_ring_phase",   32'(phase),   'h0);
    chk_on = 1'b1;

    // Johnson up from reset, 8 steps.
    @(negedge clk); #1;
    rst = 1'b0; mode = 2'b01; en = 1'b1; dir = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("jup_q",     32'(q),     32'(jup[i]));
      check("jup_phase", 32'(phase), (i == 7) ? 0 : i + 1);
      check("jup_wrap",  32'(wrap),  (i == 7) ? 1 : 0);
    end

    // Johnson down from 0000, one step.
    #1 dir = 1'b1;
    @(negedge clk);
    check("jdn_q",     32'(q),     'h1);
    check("jdn_phase", 32'(phase), 7);
    check("jdn_wrap",  32'(wrap),  'h1);
    #1 en = 1'b0;
    @(negedge clk);
    check("jdn_wrap_drop", 32'(wrap), 'h0);
    check("jdn_freeze_q",  32'(q),    'h1);

    // Ring up after loading MSB-only.
    #1 mode = 2'b10; dir = 1'b0; en = 1'b1; load = 1'b1; load_val = 4'b1000;
    @(negedge clk);
    check("rload_q",    32'(q),    'h8);
    check("rload_wrap", 32'(wrap), 'h0);
    #1 load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rup_q",     32'(q),     32'(rup[i]));
      check("rup_phase", 32'(phase), (i == 3) ? 0 : i + 1);
      check("rup_wrap",  32'(wrap),  (i == 3) ? 1 : 0);
    end

    // Prescaler div=2: step every 3rd edge, load restarts the spacing.
    #1 mode = 2'b01; dir = 1'b0; div = 8'd2; load = 1'b1; load_val = 4'b0000;
    @(negedge clk); #1 load = 1'b0;
    @(negedge clk); check("div_e1", 32'(q), 'h0);
    @(negedge clk); check("div_e2", 32'(q), 'h0);
    @(negedge clk); check("div_e3", 32'(q), 'h8);
    @(negedge clk); check("div_e4", 32'(q), 'h8);
    held = q;
    #1 load = 1'b1; load_val = held;
    @(negedge clk); check("div_e5_load", 32'(q), 'h8);
    #1 load = 1'b0;
    @(negedge clk); check("div_e6", 32'(q), 'h8);
    @(negedge clk); check("div_e7", 32'(q), 'h8);
    @(negedge clk); check("div_e8", 32'(q), 'hC);

    // Illegal Johnson code, then self-correction.
    #1 div = 8'd0; load = 1'b1; load_val = 4'b1010;
    @(negedge clk);
    check("ill_q",       32'(q),       'hA);
    check("ill_illegal", 32'(illegal), 'h1);
    check("ill_phase",   32'(phase),   'h0);
    #1 load = 1'b0;
    @(negedge clk);
    check("fix_q",       32'(q),       'h0);
    check("fix_illegal", 32'(illegal), 'h0);
    check("fix_wrap",    32'(wrap),    'h0);

    // Asynchronous reset between edges at q=1110.
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("pre_rst_q", 32'(q), 'hE);
    #2 rst = 1'b1;
    #1;
    check("async_rst_q",    32'(q),    'h0);
    check("async_rst_wrap", 32'(wrap), 'h0);
    @(negedge clk);
    check("rst_hold_wrap", 32'(wrap), 'h0);
    #1 rst = 1'b0;

    // Randomized traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk); #1;
      en       = ($urandom_range(0, 7) != 0);
      mode     = 2'($urandom_range(0, 3));
      dir      = 1'($urandom_range(0, 1));
      load     = ($urandom_range(0, 15) == 0);
      load_val = 4'($urandom);
      if ($urandom_range(0, 63) == 0) div = 8'($urandom_range(0, 3));
      rst      = ($urandom_range(0, 199) == 0);
    end
    #1 rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
